// File: rtl/user_pkg.sv
// User-domain shared definitions: manager count and the copier FSM state type.
package user_pkg;

  // Number of OBI managers originating in the user domain (the copier).
  localparam int unsigned NumUserDomainManagers = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } user_copier_state_e;

endpackage

// File: rtl/user_obi_copier.sv
// Word-granular OBI copy engine for the user domain.
// Reads len_i words from src_i and writes them to dst_i, one transaction at a
// time. Optional fill mode (writes a latched pattern, no reads) is compiled in
// with `define USER_COPIER_FILL_EN.
module user_obi_copier
  import user_pkg::*;
#(
  parameter int unsigned LenWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [31:0]         src_i,
  input  logic [31:0]         dst_i,
  input  logic [LenWidth-1:0] len_i,
  input  logic                fill_i,
  input  logic [31:0]         pattern_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [LenWidth-1:0] count_o,
  output logic                obi_req_o,
  input  logic                obi_gnt_i,
  output logic [31:0]         obi_addr_o,
  output logic                obi_we_o,
  output logic [3:0]          obi_be_o,
  output logic [31:0]         obi_wdata_o,
  output logic [0:0]          obi_aid_o,
  input  logic                obi_rvalid_i,
  input  logic [31:0]         obi_rdata_i,
  input  logic                obi_err_i
);

  user_copier_state_e  state;
  logic [31:0]         src_q;
  logic [31:0]         dst_q;
  logic [31:0]         data_q;
  logic [LenWidth-1:0] len_q;
  logic [LenWidth-1:0] count_next;
  logic                fill_q;
  logic                start_fill;

  assign obi_be_o    = 4'hF;
  assign obi_aid_o   = 1'b0;
  assign obi_wdata_o = data_q;
  assign count_next  = count_o + LenWidth'(1);

`ifdef USER_COPIER_FILL_EN
  assign start_fill = fill_i;

  // Fill-mode flag held for the whole transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_q <= 1'b0;
    end else if (state == IDLE && start_i) begin
      fill_q <= fill_i;
    end
  end
`else
  logic unused_fill;
  assign start_fill  = 1'b0;
  assign fill_q      = 1'b0;
  assign unused_fill = ^{fill_i, pattern_i};
`endif

  // Transfer FSM; OBI request fields are registered on entry to each request
  // state so they stay stable until the grant. In fill mode the pattern is
  // parked in the data register, which is never reloaded since no reads occur.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      len_q      <= '0;
      count_o    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      obi_req_o  <= 1'b0;
      obi_addr_o <= '0;
      obi_we_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            src_q   <= {src_i[31:2], 2'b00};
            dst_q   <= {dst_i[31:2], 2'b00};
            len_q   <= len_i;
            count_o <= '0;
            error_o <= 1'b0;
            busy_o  <= 1'b1;
            if (start_fill) data_q <= pattern_i;
            if (len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else if (start_fill) begin
              state      <= WR_REQ;
              obi_req_o  <= 1'b1;
              obi_we_o   <= 1'b1;
              obi_addr_o <= {dst_i[31:2], 2'b00};
            end else begin
              state      <= RD_REQ;
              obi_req_o  <= 1'b1;
              obi_we_o   <= 1'b0;
              obi_addr_o <= {src_i[31:2], 2'b00};
            end
          end
        end
        RD_REQ: begin
          if (obi_gnt_i) begin
            state     <= RD_WAIT;
            obi_req_o <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (obi_rvalid_i) begin
            if (obi_err_i) begin
              error_o <= 1'b1;
              state   <= DONE;
              done_o  <= 1'b1;
            end else begin
              data_q     <= obi_rdata_i;
              state      <= WR_REQ;
              obi_req_o  <= 1'b1;
              obi_we_o   <= 1'b1;
              obi_addr_o <= dst_q;
            end
          end
        end
        WR_REQ: begin
          if (obi_gnt_i) begin
            state     <= WR_WAIT;
            obi_req_o <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (obi_rvalid_i) begin
            if (obi_err_i) begin
              error_o <= 1'b1;
              state   <= DONE;
              done_o  <= 1'b1;
            end else begin
              count_o <= count_next;
              src_q   <= src_q + 32'd4;
              dst_q   <= dst_q + 32'd4;
              if (count_next == len_q) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else if (fill_q) begin
                state      <= WR_REQ;
                obi_req_o  <= 1'b1;
                obi_we_o   <= 1'b1;
                obi_addr_o <= dst_q + 32'd4;
              end else begin
                state      <= RD_REQ;
                obi_req_o  <= 1'b1;
                obi_we_o   <= 1'b0;
                obi_addr_o <= src_q + 32'd4;
              end
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_obi_copier.sv
// Self-checking bench for user_obi_copier: memory-backed OBI responder plus a
// transaction-level reference model of the expected read/write sequence.
module tb_user_obi_copier;

  localparam int unsigned LW = 16;
`ifdef USER_COPIER_FILL_EN
  localparam bit FillEn = 1'b1;
`else
  localparam bit FillEn = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          fill = 1'b0;
  logic [31:0]   src = '0, dst = '0, pattern = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, error;
  logic [LW-1:0] count;
  logic          req, we;
  logic          gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
  logic [31:0]   addr, wdata;
  logic [31:0]   rdata = '0;
  logic [3:0]    be;
  logic [0:0]    aid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  user_obi_copier #(.LenWidth(LW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .src_i(src), .dst_i(dst),
    .len_i(len), .fill_i(fill), .pattern_i(pattern),
    .busy_o(busy), .done_o(done), .error_o(error), .count_o(count),
    .obi_req_o(req), .obi_gnt_i(gnt), .obi_addr_o(addr), .obi_we_o(we),
    .obi_be_o(be), .obi_wdata_o(wdata), .obi_aid_o(aid),
    .obi_rvalid_i(rvalid), .obi_rdata_i(rdata), .obi_err_i(err)
  );

  // ---------------- memory and responder ----------------
  logic [31:0] mem [logic [31:0]];
  txn_t log_q[$];
  txn_t exp_q[$];
  int   exp_count;
  bit   exp_err;

  // responder configuration
  bit rand_mode = 1'b0;
  int resp_delay = 0;
  int rd_gnt_idx = -1, rd_gnt_cycles = 0;
  int err_rd_idx = -1, err_wr_idx = -1;
  int rd_n = 0, wr_n = 0;

  bit          pend = 1'b0, gnt_armed = 1'b0, prev_wait = 1'b0;
  int          resp_wait = 0, gnt_wait = 0;
  logic [31:0] pend_data = '0;
  logic        pend_err = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic        p_we = 1'b0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Responder: drives grant/response on the falling edge, checks request hold.
  always @(negedge clk) begin
    rvalid = 1'b0;
    err    = 1'b0;
    gnt    = 1'b0;
    rdata  = $urandom;
    if (pend) begin
      if (resp_wait > 0) resp_wait--;
      else begin
        rvalid = 1'b1;
        rdata  = pend_data;
        err    = pend_err;
        pend   = 1'b0;
      end
    end
    if (prev_wait) begin
      checks++;
      if (req !== 1'b1 || addr !== p_addr || we !== p_we || (p_we && wdata !== p_wdata)) begin
        errors++;
        $display("FAIL req_hold: req=%b addr=%h we=%b wdata=%h, required req=1 addr=%h we=%b wdata=%h",
                 req, addr, we, wdata, p_addr, p_we, p_wdata);
      end
    end
    if (req === 1'b1) begin
      if (!gnt_armed) begin
        gnt_armed = 1'b1;
        if (!we && rd_n == rd_gnt_idx) gnt_wait = rd_gnt_cycles;
        else if (rand_mode)            gnt_wait = $urandom_range(0, 3);
        else                           gnt_wait = 0;
      end
      if (gnt_wait > 0) begin
        gnt_wait--;
        prev_wait = 1'b1;
        p_addr = addr; p_we = we; p_wdata = wdata;
      end else begin
        gnt       = 1'b1;
        gnt_armed = 1'b0;
        prev_wait = 1'b0;
        log_q.push_back('{we: we, addr: addr, wdata: wdata});
        pend      = 1'b1;
        resp_wait = rand_mode ? $urandom_range(0, 2) : resp_delay;
        if (we) begin
          pend_err  = (wr_n == err_wr_idx);
          pend_data = $urandom;
          if (!pend_err) mem[addr] = wdata;
          wr_n++;
        end else begin
          pend_err  = (rd_n == err_rd_idx);
          pend_data = rd_mem(addr);
          rd_n++;
        end
      end
    end else begin
      prev_wait = 1'b0;
      gnt_armed = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Expected OBI sequence: per word, read src+4i then write dst+4i (fill: write
  // only, with the pattern); an error response ends the transfer after it.
  function automatic void build_exp(input logic [31:0] s, input logic [31:0] d, input int n,
                                    input bit fillm, input logic [31:0] p,
                                    input int rerr, input int werr);
    logic [31:0] sa, da;
    exp_q.delete();
    exp_count = 0;
    exp_err   = 1'b0;
    for (int i = 0; i < n; i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      if (!fillm) begin
        exp_q.push_back('{we: 1'b0, addr: sa, wdata: 32'h0});
        if (i == rerr) begin exp_err = 1'b1; break; end
      end
      exp_q.push_back('{we: 1'b1, addr: da, wdata: fillm ? p : rd_mem(sa)});
      if (i == werr) begin exp_err = 1'b1; break; end
      exp_count++;
    end
  endfunction

  function automatic int first_log_diff();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= log_q.size()) return i;
      if (log_q[i].we !== exp_q[i].we || log_q[i].addr !== exp_q[i].addr ||
          (exp_q[i].we && log_q[i].wdata !== exp_q[i].wdata)) return i;
    end
    if (log_q.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  // Pulse start at cycle 0 and wait (bounded) for done; cycle index of done is
  // returned. Optionally pulses start again at cycle restart_at with other args.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] l,
                          input logic f, input logic [31:0] p, input int restart_at,
                          output int done_cyc);
    int cyc;
    rd_n = 0; wr_n = 0;
    log_q.delete();
    @(negedge clk);
    src = s; dst = d; len = l; fill = f; pattern = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    done_cyc = -1;
    while (cyc < 3000) begin
      if (done === 1'b1) begin done_cyc = cyc; break; end
      if (cyc == restart_at) begin
        start = 1'b1; src = ~s; dst = ~d; len = l + LW'(3); fill = ~f;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, required done", cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, req, we, aid} !== 6'b0 || count !== '0 || addr !== '0 || wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b error=%b req=%b we=%b aid=%b count=%0d addr=%h wdata=%h, required all 0",
               busy, done, error, req, we, aid, count, addr, wdata);
    end
    checks++;
    if (be !== 4'hF) begin
      errors++;
      $display("FAIL reset_be: be=%h, required f", be);
    end
    rst = 1'b0;
  endtask

  task automatic test_copy_basic();
    int dc;
    build_exp(32'h1000_0000, 32'h1000_0100, 3, 1'b0, 32'h0, -1, -1);
    run_xfer(32'h1000_0000, 32'h1000_0100, LW'(3), 1'b0, 32'h0, -1, dc);
    checks++;
    if (dc !== 13) begin errors++; $display("FAIL basic_done_cycle: got %0d, required 13", dc); end
    checks++;
    if (first_log_diff() != -1) begin
      errors++; $display("FAIL basic_txn_seq: first diff at %0d (got %0d txns, required %0d)", first_log_diff(), log_q.size(), exp_q.size());
    end
    checks++;
    if (count !== LW'(3) || error !== 1'b0) begin
      errors++; $display("FAIL basic_status: count=%0d error=%b, required 3 0", count, error);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_mem(32'h1000_0100 + 32'(4 * i)) !== rd_mem(32'h1000_0000 + 32'(4 * i))) begin
        errors++; $display("FAIL basic_dst_word%0d: got %h, required %h", i,
                           rd_mem(32'h1000_0100 + 32'(4 * i)), rd_mem(32'h1000_0000 + 32'(4 * i)));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_gnt_stall();
    int dc;
    rd_gnt_idx = 1; rd_gnt_cycles = 5;
    build_exp(32'h1000_0000, 32'h1000_0200, 3, 1'b0, 32'h0, -1, -1);
    run_xfer(32'h1000_0000, 32'h1000_0200, LW'(3), 1'b0, 32'h0, -1, dc);
    rd_gnt_idx = -1;
    checks++;
    if (dc !== 18) begin errors++; $display("FAIL stall_done_cycle: got %0d, required 18", dc); end
    checks++;
    if (first_log_diff() != -1 || count !== LW'(3)) begin
      errors++; $display("FAIL stall_result: diff at %0d count=%0d, required -1 3", first_log_diff(), count);
    end
  endtask

  task automatic test_write_error();
    int dc, n;
    err_wr_idx = 1;
    build_exp(32'h1000_1000, 32'h1000_2000, 3, 1'b0, 32'h0, -1, 1);
    run_xfer(32'h1000_1000, 32'h1000_2000, LW'(3), 1'b0, 32'h0, -1, dc);
    err_wr_idx = -1;
    checks++;
    if (dc !== 9) begin errors++; $display("FAIL werr_done_cycle: got %0d, required 9", dc); end
    checks++;
    if (error !== 1'b1 || count !== LW'(1)) begin
      errors++; $display("FAIL werr_status: error=%b count=%0d, required 1 1", error, count);
    end
    n = log_q.size();
    repeat (6) @(negedge clk);
    checks++;
    if (first_log_diff() != -1 || log_q.size() != n || req !== 1'b0) begin
      errors++; $display("FAIL werr_no_more_req: txns=%0d req=%b, required %0d 0", log_q.size(), req, exp_q.size());
    end
    build_exp(32'h1000_3000, 32'h1000_4000, 1, 1'b0, 32'h0, -1, -1);
    run_xfer(32'h1000_3000, 32'h1000_4000, LW'(1), 1'b0, 32'h0, -1, dc);
    checks++;
    if (error !== 1'b0 || dc !== 5) begin
      errors++; $display("FAIL werr_restart_clears: error=%b done_cycle=%0d, required 0 5", error, dc);
    end
  endtask

  task automatic test_len_zero_and_busy_start();
    int dc;
    run_xfer(32'h1000_5000, 32'h1000_6000, LW'(0), 1'b0, 32'h0, -1, dc);
    checks++;
    if (dc !== 1 || log_q.size() != 0 || count !== '0) begin
      errors++; $display("FAIL len0: done_cycle=%0d txns=%0d count=%0d, required 1 0 0", dc, log_q.size(), count);
    end
    build_exp(32'h1000_7000, 32'h1000_8000, 2, 1'b0, 32'h0, -1, -1);
    run_xfer(32'h1000_7000, 32'h1000_8000, LW'(2), 1'b0, 32'h0, 3, dc);
    checks++;
    if (dc !== 9 || first_log_diff() != -1 || count !== LW'(2)) begin
      errors++; $display("FAIL busy_start_ignored: done_cycle=%0d diff=%0d count=%0d, required 9 -1 2", dc, first_log_diff(), count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req !== 1'b0) begin
      errors++; $display("FAIL busy_start_no_relaunch: busy=%b req=%b, required 0 0", busy, req);
    end
  endtask

  task automatic test_wrap();
    int dc;
    build_exp(32'h4000_0000, 32'hFFFF_FFFC, 2, 1'b0, 32'h0, -1, -1);
    run_xfer(32'h4000_0000, 32'hFFFF_FFFC, LW'(2), 1'b0, 32'h0, -1, dc);
    checks++;
    if (log_q.size() != 4 || log_q[3].addr !== 32'h0 || first_log_diff() != -1) begin
      errors++; $display("FAIL wrap_dst: txns=%0d diff=%0d, required 4 -1 with last write to 00000000",
                         log_q.size(), first_log_diff());
    end
    checks++;
    if (rd_mem(32'h0) !== rd_mem(32'h4000_0004) || error !== 1'b0) begin
      errors++; $display("FAIL wrap_word: mem[0]=%h error=%b, required %h 0", rd_mem(32'h0), error, rd_mem(32'h4000_0004));
    end
  endtask

  task automatic test_fill();
    int dc;
    build_exp(32'h5000_0000, 32'h6000_0000, 4, FillEn, 32'hDEAD_BEEF, -1, -1);
    run_xfer(32'h5000_0000, 32'h6000_0000, LW'(4), 1'b1, 32'hDEAD_BEEF, -1, dc);
    checks++;
    if (dc !== (FillEn ? 9 : 17)) begin
      errors++; $display("FAIL fill_done_cycle: got %0d, required %0d", dc, FillEn ? 9 : 17);
    end
    checks++;
    if (first_log_diff() != -1 || count !== LW'(4)) begin
      errors++; $display("FAIL fill_txn_seq: diff=%0d txns=%0d count=%0d, required -1 %0d 4",
                         first_log_diff(), log_q.size(), count, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int guard;
    resp_delay = 3;
    rd_n = 0; wr_n = 0;
    @(negedge clk);
    src = 32'h7000_0000; dst = 32'h7000_1000; len = LW'(4); fill = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (rd_n == 0 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resp_delay = 0;
    checks++;
    if (req !== 1'b0 || busy !== 1'b0 || count !== '0 || rd_n != 1) begin
      errors++; $display("FAIL rst_mid: req=%b busy=%b count=%0d reads=%0d, required 0 0 0 1", req, busy, count, rd_n);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL rst_late_rvalid c%0d: req=%b busy=%b done=%b, required 0 0 0", i, req, busy, done);
      end
    end
  endtask

  task automatic test_random();
    int dc, n, rerr, werr;
    logic [31:0] s, d, p;
    logic f;
    rand_mode = 1'b1;
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 8);
      s = 32'h2000_0000 + 32'(it * 32'h1000) + {$urandom_range(0, 63), 2'b00};
      d = 32'h3000_0000 + 32'(it * 32'h1000) + {$urandom_range(0, 63), 2'b00};
      p = $urandom;
      f = 1'($urandom_range(0, 1));
      rerr = -1; werr = -1;
      case ($urandom_range(0, 3))
        0: rerr = $urandom_range(0, n - 1);
        1: werr = $urandom_range(0, n - 1);
        default: ;
      endcase
      err_rd_idx = rerr; err_wr_idx = werr;
      build_exp(s, d, n, f && FillEn, p, rerr, werr);
      run_xfer(s, d, LW'(n), f, p, -1, dc);
      checks++;
      if (first_log_diff() != -1 || count !== LW'(exp_count) || error !== exp_err) begin
        errors++; $display("FAIL random_it%0d: diff=%0d count=%0d error=%b, required -1 %0d %b",
                           it, first_log_diff(), count, error, exp_count, exp_err);
      end
    end
    err_rd_idx = -1; err_wr_idx = -1;
    rand_mode = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_copy_basic();
    test_gnt_stall();
    test_write_error();
    test_len_zero_and_busy_start();
    test_wrap();
    test_fill();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
